complex_accum: RTL and testbench
================================

Name: complex_accum

Overview:
- Downstream consumer of the complex multiplier's product outputs (preal/pimag, signed Q10.5, 15 bits, bit range [9:-5]).
- Sums N_ACC consecutive complex products into a wider saturating accumulator, then presents the sum on a valid/ready output port.
- Provides in_ready so the upstream operand sequencer does not issue a new multiply while a finished sum is still waiting to be taken.

Parameters:
- N_ACC, 4, number of products summed per result; legal range 1..255.
- ACC_W, 20, total accumulator width in bits (signed, 5 fractional bits); must be >= 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- clr  input  1  synchronous clear: abandons the partial sum and returns to IDLE.
- in_valid  input  1  one-cycle strobe: preal/pimag hold a finished product.
- preal  input  15  signed Q10.5 real product.
- pimag  input  15  signed Q10.5 imaginary product.
- in_ready  output  1  block can accept a product this cycle.
- acc_real  output  ACC_W  signed accumulated real sum, 5 fractional bits.
- acc_imag  output  ACC_W  signed accumulated imaginary sum, 5 fractional bits.
- out_valid  output  1  acc_real/acc_imag hold a completed result.
- out_ready  input  1  consumer accepts the result this cycle.
- sat  output  1  result saturated; valid while out_valid=1.
- overrun  output  1  sticky: a product arrived while in_ready=0.
- cnt  output  8  number of products accepted in the current burst.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, acc_real=0, acc_imag=0, cnt=0, out_valid=0, sat=0, overrun=0. Reset also aborts any burst in progress.
- Acceptance: a product is accepted on a rising edge with in_valid=1 and in_ready=1.
- in_ready = 1 in IDLE and ACCUM. In HOLD, in_ready = out_ready (combinational).
- Arithmetic: preal/pimag are sign-extended to ACC_W; no shift is applied, so the 5 fractional bits line up.
- Each add is computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Any clamp on either the real or the imaginary component sets the sat flag for the current burst.
- IDLE:
  - Accepted product: acc = extended sample (overwrites any old value), cnt=1, sat=0.
  - If N_ACC=1 go to HOLD, else go to ACCUM.
- ACCUM:
  - Accepted product: acc = sat_add(acc, sample), cnt += 1.
  - When cnt reaches N_ACC, go to HOLD.
- HOLD:
  - out_valid=1; acc_real, acc_imag and sat stay stable until handshake.
  - Result latency: out_valid rises the cycle after the N_ACC-th product is accepted.
- Handshake (out_valid=1 and out_ready=1):
  - Result is transferred and out_valid falls next cycle.
  - If in_valid=1 in the same cycle, that product is accepted as the first sample of the next burst: acc = sample, cnt=1, sat=0, state = ACCUM (or HOLD when N_ACC=1).
  - Otherwise state = IDLE; acc keeps its value, cnt=0.
- Overrun: in_valid=1 while in_ready=0 sets overrun=1 and the sample is dropped. overrun clears only on reset or clr.
- clr=1:
  - Next state IDLE, acc=0, cnt=0, out_valid=0, sat=0, overrun=0.
  - Any in_valid in the same cycle is ignored.
  - clr has priority over all other events.
- Outputs are registered except in_ready.

Test Plan:
- Reset mid-burst: after 2 of 4 products, pulse reset=0 asynchronously (not clock-aligned) -> all outputs 0 immediately; the next burst starts from cnt=1.
- Basic sum, N_ACC=4, ACC_W=20, out_ready=1: four strobes of preal=1248 (39.0), pimag=832 (26.0), spaced 11 cycles apart -> out_valid high one cycle after the 4th strobe with acc_real=4992 (156.0), acc_imag=3328 (104.0), sat=0.
- Backpressure: out_ready=0 after completion -> out_valid and outputs stable for 20 cycles, in_ready=0; a strobe during that time sets overrun=1 and acc is unchanged.
- Simultaneous handshake and input: out_ready=1 with in_valid=1, preal=-32 (-1.0), pimag=0 -> result transferred; next cycle acc_real=-32, acc_imag=0, cnt=1, state ACCUM.
- Saturation, ACC_W=16: three strobes of preal=16383, pimag=-16384 -> acc_real=32767, acc_imag=-32768, sat=1.
- clr during ACCUM (cnt=2) with in_valid=1 in the same cycle -> next cycle cnt=0, acc=0, overrun=0, sample ignored; N_ACC=1 variant: each strobe yields out_valid the next cycle with acc = sample.

Source files
------------

// File: rtl/complex_accum.sv
// complex_accum: sums N_ACC complex Q10.5 products into saturating ACC_W accumulators.
// Ports: clk, reset (async, active-low), clr, in_valid/in_ready with preal/pimag,
//        out_valid/out_ready with acc_real/acc_imag/sat, sticky overrun, burst count cnt.
module complex_accum #(
    parameter int N_ACC = 4,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [14:0]      preal,
    input  logic signed [14:0]      pimag,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] acc_real,
    output logic signed [ACC_W-1:0] acc_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat,
    output logic                    overrun,
    output logic [7:0]              cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [7:0] N_LAST  = 8'(N_ACC);
    localparam logic       ONE_SHOT = (N_ACC == 1);

    logic [1:0]             r_state;
    logic [ACC_W-1:0]       r_acc_re;
    logic [ACC_W-1:0]       r_acc_im;
    logic [7:0]             r_cnt;
    logic                   r_out_valid;
    logic                   r_sat;
    logic                   r_overrun;

    logic                   w_in_ready;
    logic                   w_accept;
    logic signed [ACC_W-1:0] w_ext_re;
    logic signed [ACC_W-1:0] w_ext_im;
    logic [ACC_W:0]         w_sum_re;
    logic [ACC_W:0]         w_sum_im;
    logic [7:0]             w_cnt_nxt;
    logic                   w_last;

    // Returns {clamped, value}: add at ACC_W+1 bits, clamp on sign disagreement.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0]   s;
        logic [ACC_W-1:0] maxv;
        logic [ACC_W-1:0] minv;
        s    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        maxv = {1'b0, {(ACC_W-1){1'b1}}};
        minv = {1'b1, {(ACC_W-1){1'b0}}};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, (s[ACC_W] ? minv : maxv)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // A finished result only blocks new input until the consumer takes it.
    assign w_in_ready = (r_state == S_HOLD) ? out_ready : 1'b1;
    assign w_accept   = in_valid && w_in_ready;

    assign w_ext_re  = ACC_W'(preal);
    assign w_ext_im  = ACC_W'(pimag);
    assign w_sum_re  = sat_add(r_acc_re, w_ext_re);
    assign w_sum_im  = sat_add(r_acc_im, w_ext_im);
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_last    = (w_cnt_nxt == N_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready)
                r_overrun <= 1'b1;
            unique case (r_state)
                S_IDLE, S_HOLD: begin
                    // First sample of a burst overwrites the old sum.
                    if (w_accept) begin
                        r_acc_re    <= w_ext_re;
                        r_acc_im    <= w_ext_im;
                        r_cnt       <= 8'd1;
                        r_sat       <= 1'b0;
                        r_state     <= ONE_SHOT ? S_HOLD : S_ACCUM;
                        r_out_valid <= ONE_SHOT;
                    end else if (r_state == S_HOLD && out_ready) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc_re <= w_sum_re[ACC_W-1:0];
                        r_acc_im <= w_sum_im[ACC_W-1:0];
                        r_sat    <= r_sat | w_sum_re[ACC_W] | w_sum_im[ACC_W];
                        r_cnt    <= w_cnt_nxt;
                        if (w_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign acc_real  = r_acc_re;
    assign acc_imag  = r_acc_im;
    assign out_valid = r_out_valid;
    assign sat       = r_sat;
    assign overrun   = r_overrun;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_complex_accum.sv
// tb_complex_accum: directed checks of complex_accum in three configurations
// (N_ACC=4/ACC_W=20, N_ACC=3/ACC_W=16, N_ACC=1/ACC_W=20) sharing one input bus.
module tb_complex_accum;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic signed [14:0] preal = '0;
    logic signed [14:0] pimag = '0;
    logic out_ready = 1'b1;

    logic in_ready_a, out_valid_a, sat_a, overrun_a;
    logic signed [19:0] acc_real_a, acc_imag_a;
    logic [7:0] cnt_a;

    logic in_ready_b, out_valid_b, sat_b, overrun_b;
    logic signed [15:0] acc_real_b, acc_imag_b;
    logic [7:0] cnt_b;

    logic in_ready_c, out_valid_c, sat_c, overrun_c;
    logic signed [19:0] acc_real_c, acc_imag_c;
    logic [7:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    complex_accum #(.N_ACC(4), .ACC_W(20)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
        .preal(preal), .pimag(pimag), .in_ready(in_ready_a),
        .acc_real(acc_real_a), .acc_imag(acc_imag_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .sat(sat_a), .overrun(overrun_a), .cnt(cnt_a)
    );

    complex_accum #(.N_ACC(3), .ACC_W(16)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
        .preal(preal), .pimag(pimag), .in_ready(in_ready_b),
        .acc_real(acc_real_b), .acc_imag(acc_imag_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .sat(sat_b), .overrun(overrun_b), .cnt(cnt_b)
    );

    complex_accum #(.N_ACC(1), .ACC_W(20)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
        .preal(preal), .pimag(pimag), .in_ready(in_ready_c),
        .acc_real(acc_real_c), .acc_imag(acc_imag_c),
        .out_valid(out_valid_c), .out_ready(out_ready),
        .sat(sat_c), .overrun(overrun_c), .cnt(cnt_c)
    );

    // One-cycle strobe; returns at the negedge after the accepting edge.
    task automatic strobe(input int pr, input int pi);
        @(negedge clk);
        in_valid = 1'b1;
        preal = 15'(pr);
        pimag = 15'(pi);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (acc_real_a !== 20'(0) || acc_imag_a !== 20'(0)) begin
            errors++;
            $display("FAIL reset_acc: got %0d/%0d want 0/0", acc_real_a, acc_imag_a);
        end
        checks++;
        if ({out_valid_a, sat_a, overrun_a, cnt_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags: got ov=%b sat=%b orun=%b cnt=%0d want 0",
                     out_valid_a, sat_a, overrun_a, cnt_a);
        end
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready_a);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        strobe(100, 50);
        strobe(100, 50);
        checks++;
        if (cnt_a !== 8'd2 || acc_real_a !== 20'(200)) begin
            errors++;
            $display("FAIL mid_pre: got cnt=%0d re=%0d want 2/200", cnt_a, acc_real_a);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 8'd0 || acc_real_a !== 20'(0) || acc_imag_a !== 20'(0)
            || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got cnt=%0d re=%0d im=%0d ov=%b want 0",
                     cnt_a, acc_real_a, acc_imag_a, out_valid_a);
        end
        @(negedge clk);
        reset = 1'b1;
        strobe(100, 50);
        checks++;
        if (cnt_a !== 8'd1 || acc_real_a !== 20'(100) || acc_imag_a !== 20'(50)) begin
            errors++;
            $display("FAIL mid_restart: got cnt=%0d re=%0d im=%0d want 1/100/50",
                     cnt_a, acc_real_a, acc_imag_a);
        end
    endtask

    task automatic test_basic();
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(1248, 832);
            if (i == 2) begin
                checks++;
                if (cnt_a !== 8'd3 || out_valid_a !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_3rd: got cnt=%0d ov=%b want 3/0", cnt_a, out_valid_a);
                end
            end
            if (i < 3) repeat (10) @(negedge clk);
        end
        checks++;
        if (out_valid_a !== 1'b1 || acc_real_a !== 20'(4992)
            || acc_imag_a !== 20'(3328) || sat_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got ov=%b re=%0d im=%0d sat=%b want 1/4992/3328/0",
                     out_valid_a, acc_real_a, acc_imag_a, sat_a);
        end
        @(negedge clk);
        checks++;
        if (out_valid_a !== 1'b0 || cnt_a !== 8'd0 || acc_real_a !== 20'(4992)) begin
            errors++;
            $display("FAIL basic_taken: got ov=%b cnt=%0d re=%0d want 0/0/4992",
                     out_valid_a, cnt_a, acc_real_a);
        end
    endtask

    task automatic test_backpressure();
        logic stable;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(100, -200);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0
                || acc_real_a !== 20'(400) || acc_imag_a !== 20'(-800)) stable = 1'b0;
            if (i == 10) begin
                in_valid = 1'b1;
                preal = 15'(7);
                pimag = 15'(7);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable: got ov=%b rdy=%b re=%0d im=%0d want 1/0/400/-800",
                     out_valid_a, in_ready_a, acc_real_a, acc_imag_a);
        end
        checks++;
        if (overrun_a !== 1'b1 || acc_real_a !== 20'(400) || cnt_a !== 8'd4) begin
            errors++;
            $display("FAIL bp_overrun: got orun=%b re=%0d cnt=%0d want 1/400/4",
                     overrun_a, acc_real_a, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b want 1", in_ready_a);
        end
        in_valid = 1'b1;
        preal = 15'(-32);
        pimag = 15'(0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid_a !== 1'b0 || acc_real_a !== 20'(-32) || acc_imag_a !== 20'(0)
            || cnt_a !== 8'd1 || overrun_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_next: got ov=%b re=%0d im=%0d cnt=%0d orun=%b want 0/-32/0/1/1",
                     out_valid_a, acc_real_a, acc_imag_a, cnt_a, overrun_a);
        end
    endtask

    task automatic test_clr();
        strobe(10, 10);
        checks++;
        if (cnt_a !== 8'd2 || acc_real_a !== 20'(-22)) begin
            errors++;
            $display("FAIL clr_pre: got cnt=%0d re=%0d want 2/-22", cnt_a, acc_real_a);
        end
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b1;
        preal = 15'(500);
        pimag = 15'(500);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (cnt_a !== 8'd0 || acc_real_a !== 20'(0) || acc_imag_a !== 20'(0)
            || overrun_a !== 1'b0 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: got cnt=%0d re=%0d im=%0d orun=%b ov=%b want 0",
                     cnt_a, acc_real_a, acc_imag_a, overrun_a, out_valid_a);
        end
    endtask

    task automatic test_saturation();
        do_clr();
        out_ready = 1'b1;
        strobe(16383, -16384);
        strobe(16383, -16384);
        checks++;
        if (acc_real_b !== 16'(32766) || acc_imag_b !== 16'(-32768) || sat_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_edge: got re=%0d im=%0d sat=%b want 32766/-32768/0",
                     acc_real_b, acc_imag_b, sat_b);
        end
        strobe(16383, -16384);
        checks++;
        if (acc_real_b !== 16'(32767) || acc_imag_b !== 16'(-32768)
            || sat_b !== 1'b1 || out_valid_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp: got re=%0d im=%0d sat=%b ov=%b want 32767/-32768/1/1",
                     acc_real_b, acc_imag_b, sat_b, out_valid_b);
        end
    endtask

    task automatic test_n1();
        do_clr();
        out_ready = 1'b1;
        strobe(1248, -832);
        checks++;
        if (out_valid_c !== 1'b1 || acc_real_c !== 20'(1248)
            || acc_imag_c !== 20'(-832) || cnt_c !== 8'd1) begin
            errors++;
            $display("FAIL n1_first: got ov=%b re=%0d im=%0d cnt=%0d want 1/1248/-832/1",
                     out_valid_c, acc_real_c, acc_imag_c, cnt_c);
        end
        strobe(-32, 64);
        checks++;
        if (out_valid_c !== 1'b1 || acc_real_c !== 20'(-32) || acc_imag_c !== 20'(64)) begin
            errors++;
            $display("FAIL n1_b2b: got ov=%b re=%0d im=%0d want 1/-32/64",
                     out_valid_c, acc_real_c, acc_imag_c);
        end
        @(negedge clk);
        checks++;
        if (out_valid_c !== 1'b0 || cnt_c !== 8'd0 || acc_real_c !== 20'(-32)) begin
            errors++;
            $display("FAIL n1_idle: got ov=%b cnt=%0d re=%0d want 0/0/-32",
                     out_valid_c, cnt_c, acc_real_c);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_saturation();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
